// File: rtl/fifo_egress_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fifo_egress_arbiter_pkg
//   Shared definitions for the FIFO egress arbiter slice: default geometry,
//   the tail-flag position inside the control field, the scheduler state
//   encoding and a small helper used to derive the busy indication.
//
//   Optional feature macro: FIFO_ARB_PKT_LOCK_EN (see fifo_egress_arbiter.sv).
// -----------------------------------------------------------------------------
package fifo_egress_arbiter_pkg;

  // Default geometry of one arbiter instance.
  localparam int NUM_PORTS_DEF          = 4;
  localparam int LOG2_NUM_PORTS_DEF     = 2;
  localparam int DATA_LINE_WIDTH_DEF    = 64;
  localparam int CONTROL_LINE_WIDTH_DEF = 6;

  // Bit within the control field that marks the last flit of a packet.
  localparam int TAIL_BIT = 0;

  // Scheduler states. Encodings are fixed so that state can be decoded
  // directly from a register dump.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_PRESENT = 2'd3
  } arb_state_e;

  // Busy whenever a flit is in flight or a packet still owns the egress.
  function automatic logic arb_is_busy(input arb_state_e state, input logic pkt_open);
    return (state != ST_IDLE) || pkt_open;
  endfunction

endpackage

// File: rtl/fifo_egress_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_egress_arbiter_if
//   Bundles the FIFO-side and egress-side signals of the arbiter.
//   Signal names keep the arbiter's point of view (i_ = into arbiter).
//
//   i_fifo_empty       [NUM_PORTS]    per-port fifo empty flag
//   o_fifo_read_en     [NUM_PORTS]    per-port fifo read enable
//   i_fifo_read_packet [NUM_PORTS*W]  per-port fifo read data, port p at [p*W +: W]
//   o_packet           [W]            egress flit
//   o_packet_valid                    egress flit valid
//   i_packet_ready                    egress sink ready
//   o_grant_id         [LOG2]         port currently owning the egress
//   o_busy                            scheduler busy / packet open
//
//   Modports: master = arbiter side, slave = fifo bank + egress sink side.
// -----------------------------------------------------------------------------
interface fifo_egress_arbiter_if
  import fifo_egress_arbiter_pkg::*;
#(
  parameter int NUM_PORTS          = NUM_PORTS_DEF,
  parameter int LOG2_NUM_PORTS     = LOG2_NUM_PORTS_DEF,
  parameter int DATA_LINE_WIDTH    = DATA_LINE_WIDTH_DEF,
  parameter int CONTROL_LINE_WIDTH = CONTROL_LINE_WIDTH_DEF
);
  localparam int W = DATA_LINE_WIDTH + CONTROL_LINE_WIDTH;

  logic [NUM_PORTS-1:0]      i_fifo_empty;
  logic [NUM_PORTS-1:0]      o_fifo_read_en;
  logic [NUM_PORTS*W-1:0]    i_fifo_read_packet;
  logic [W-1:0]              o_packet;
  logic                      o_packet_valid;
  logic                      i_packet_ready;
  logic [LOG2_NUM_PORTS-1:0] o_grant_id;
  logic                      o_busy;

  modport master (
    input  i_fifo_empty, i_fifo_read_packet, i_packet_ready,
    output o_fifo_read_en, o_packet, o_packet_valid, o_grant_id, o_busy
  );

  modport slave (
    output i_fifo_empty, i_fifo_read_packet, i_packet_ready,
    input  o_fifo_read_en, o_packet, o_packet_valid, o_grant_id, o_busy
  );

endinterface

// File: rtl/fifo_egress_arbiter_rr_priority_pick.sv
// -----------------------------------------------------------------------------
// rr_priority_pick
//   Combinational round-robin pick: returns the first set bit of req found
//   scanning upward from base+1, wrapping modulo NUM_PORTS. base itself is
//   examined last, so the most recent winner has lowest priority.
//
//   req   [NUM_PORTS]  request vector (one bit per port)
//   base  [LOG2]       index of the last winner
//   found              at least one request present
//   idx   [LOG2]       winning port (0 when found=0)
// -----------------------------------------------------------------------------
module rr_priority_pick #(
  parameter int NUM_PORTS      = 4,
  parameter int LOG2_NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0]      req,
  input  logic [LOG2_NUM_PORTS-1:0] base,
  output logic                      found,
  output logic [LOG2_NUM_PORTS-1:0] idx
);

  logic [LOG2_NUM_PORTS-1:0] w_port;

  always_comb begin
    // NOTE: every output of this block is given a default before the scan so
    // no path leaves it unassigned and no latch is inferred.
    found  = 1'b0;
    idx    = '0;
    w_port = '0;
    for (int off = 1; off <= NUM_PORTS; off++) begin
      w_port = LOG2_NUM_PORTS'((int'(base) + off) % NUM_PORTS);
      if (!found && req[w_port]) begin
        found = 1'b1;
        idx   = w_port;
      end
    end
  end

endmodule

// File: rtl/fifo_egress_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_egress_arbiter
//   Round-robin scheduler draining NUM_PORTS packet FIFOs onto one egress
//   link with a valid/ready handshake. Each flit takes four cycles:
//     IDLE    choose a port and raise its read enable
//     ISSUE   read enable is sampled by the fifo at the end of this cycle
//     CAPTURE fifo read data is now valid; register it onto o_packet
//     PRESENT hold the flit until the sink accepts it
//
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     bus (fifo_egress_arbiter_if.master)
//       i_fifo_empty / o_fifo_read_en / i_fifo_read_packet   fifo bank side
//       o_packet / o_packet_valid / i_packet_ready           egress side
//       o_grant_id / o_busy                                  status
//
//   Configuration macro FIFO_ARB_PKT_LOCK_EN:
//     defined   - a port keeps the egress from its first flit through the
//                 flit whose control[TAIL_BIT] is set (packet lock).
//     undefined - arbitration per flit; control field is passed through.
//
//   A flit already popped from a fifo when reset asserts is discarded; the
//   fifos themselves must be reset or flushed alongside this block.
// -----------------------------------------------------------------------------
module fifo_egress_arbiter
  import fifo_egress_arbiter_pkg::*;
#(
  parameter int NUM_PORTS          = NUM_PORTS_DEF,
  parameter int LOG2_NUM_PORTS     = LOG2_NUM_PORTS_DEF,
  parameter int DATA_LINE_WIDTH    = DATA_LINE_WIDTH_DEF,
  parameter int CONTROL_LINE_WIDTH = CONTROL_LINE_WIDTH_DEF
) (
  input logic                   clk,
  input logic                   rst_n,
  fifo_egress_arbiter_if.master bus
);

  localparam int W = DATA_LINE_WIDTH + CONTROL_LINE_WIDTH;

  arb_state_e                r_state;
  logic [NUM_PORTS-1:0]      r_read_en;
  logic [W-1:0]              r_packet;
  logic                      r_packet_valid;
  logic [LOG2_NUM_PORTS-1:0] r_grant;
  logic [LOG2_NUM_PORTS-1:0] r_rr_last;

  logic                      w_pick_found;
  logic [LOG2_NUM_PORTS-1:0] w_pick_idx;
  logic                      w_win_found;
  logic [LOG2_NUM_PORTS-1:0] w_win_idx;
  logic [W-1:0]              w_sel_flit;
  logic                      w_transfer;
  logic                      w_pkt_open;

  // Round-robin candidate among all non-empty ports.
  rr_priority_pick #(
    .NUM_PORTS      (NUM_PORTS),
    .LOG2_NUM_PORTS (LOG2_NUM_PORTS)
  ) u_pick (
    .req   (~bus.i_fifo_empty),
    .base  (r_rr_last),
    .found (w_pick_found),
    .idx   (w_pick_idx)
  );

  // While a packet is open only the owning port may be served; an empty
  // owner simply stalls the scheduler instead of releasing the grant.
  assign w_win_found = w_pkt_open ? ~bus.i_fifo_empty[r_grant] : w_pick_found;
  assign w_win_idx   = w_pkt_open ? r_grant                     : w_pick_idx;

  // Read data of the granted port.
  always_comb begin
    w_sel_flit = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (r_grant == LOG2_NUM_PORTS'(p)) begin
        w_sel_flit = bus.i_fifo_read_packet[p*W +: W];
      end
    end
  end

  assign w_transfer = r_packet_valid & bus.i_packet_ready;

`ifdef FIFO_ARB_PKT_LOCK_EN
  logic r_pkt_open;
  logic w_tail;

  assign w_tail     = r_packet[DATA_LINE_WIDTH + TAIL_BIT];
  assign w_pkt_open = r_pkt_open;

  // Packet ownership opens on any non-tail flit and closes on the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_open <= 1'b0;
    end else if (r_state == ST_PRESENT && w_transfer) begin
      r_pkt_open <= ~w_tail;
    end
  end
`else
  assign w_pkt_open = 1'b0;
`endif

  // Scheduler FSM with all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_read_en      <= '0;
      r_packet       <= '0;
      r_packet_valid <= 1'b0;
      r_grant        <= '0;
      r_rr_last      <= LOG2_NUM_PORTS'(NUM_PORTS - 1);
    end else begin
      // NOTE: state registers use non-blocking assignments so every branch
      // sees the pre-edge values, independent of statement order.
      case (r_state)
        ST_IDLE: begin
          if (w_win_found) begin
            r_grant   <= w_win_idx;
            r_read_en <= NUM_PORTS'(1) << w_win_idx;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Fifo pops at the edge ending this cycle; drop the enable so it
          // pops exactly once.
          r_read_en <= '0;
          r_state   <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          r_packet       <= w_sel_flit;
          r_packet_valid <= 1'b1;
          r_state        <= ST_PRESENT;
        end
        ST_PRESENT: begin
          if (w_transfer) begin
            r_packet_valid <= 1'b0;
            r_rr_last      <= r_grant;
            r_state        <= ST_IDLE;
          end
        end
        default: begin
          r_read_en      <= '0;
          r_packet_valid <= 1'b0;
          r_state        <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_fifo_read_en = r_read_en;
  assign bus.o_packet       = r_packet;
  assign bus.o_packet_valid = r_packet_valid;
  assign bus.o_grant_id     = r_grant;
  assign bus.o_busy         = arb_is_busy(r_state, w_pkt_open);

endmodule
